serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder. Adds two WIDTH-bit operands one bit per clock, LSB first.
- Uses a single full-adder cell (sum = a^b^c, carry = majority(a,b,c)) and a registered carry.
- Sits where area matters more than latency and feeds results to downstream accumulate/compare logic via a start/done handshake.
- Trades WIDTH cycles of latency for one adder cell plus shift registers.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only when busy=0
a      input   WIDTH  operand A, captured on accepted start
b      input   WIDTH  operand B, captured on accepted start
cin    input   1      carry-in, captured on accepted start
busy   output  1      high while an addition is in progress
done   output  1      one-cycle pulse: sum/cout valid
sum    output  WIDTH  result, held until the next accepted start completes
cout   output  1      final carry-out, held with sum

Behaviour:
- Reset: clk is single domain; rst_n is asynchronous and active-low, with synchronous deassertion assumed at system level.
  - While rst_n=0: busy=0, done=0, sum=0, cout=0, internal carry=0, bit counter=0, state=IDLE.
- States:
  - IDLE: busy=0. start=1 at edge k captures a, b into shift registers A_sr and B_sr, cin into carry, counter=0, and clears sum_sr. Go to RUN; busy=1 from edge k.
  - RUN: at each edge, s = A_sr[0]^B_sr[0]^carry and carry <= majority(A_sr[0], B_sr[0], carry).
    - A_sr and B_sr shift right by 1.
    - sum_sr shifts right with s inserted at MSB.
    - counter increments.
  - Completion: on the edge where counter reaches WIDTH-1, i.e. edge k+WIDTH:
    - sum <= final sum_sr value (including this bit) and cout <= new carry.
    - done <= 1 and busy <= 0; return to IDLE.
- Latency: result and done are visible exactly WIDTH cycles after the start edge. done is high for exactly one cycle.
- sum/cout hold their values from completion until the next completion or reset. They do not change during a subsequent RUN; internal sum_sr is separate.
- start while busy=1 is ignored: no effect on operands, carry or counter.
- Back-to-back: start=1 in the cycle where done=1 (busy=0) is accepted. The next result follows WIDTH cycles later.
- a, b and cin are don't-care except at the accepted start edge. Later changes do not affect the in-flight operation.
- Reset mid-RUN aborts immediately to reset values. The partial result is discarded and is never flagged with done.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). There is no overflow condition beyond cout.
- Counter width is clog2(WIDTH); there is no wrap ambiguity because the counter resets on each start.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start for 1 cycle -> busy high 8 cycles; done pulses at start edge+8; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Then a=0, b=0, cin=1 -> sum=8'h01, cout=0.
- Start a=8'h10, b=8'h20; at cycle 3 of RUN, pulse start with a=8'hFF, b=8'hFF and change the a/b pins -> ignored; done at +8 with sum=8'h30, cout=0. Only one done pulse.
- Back-to-back: start with 8'h01+8'h02, then start again in the done cycle with 8'h80+8'h80 -> first done sum=8'h03 cout=0. Second done exactly 8 cycles later with sum=8'h00, cout=1. sum holds 8'h03 in between.
- Reset mid-RUN: assert rst_n=0 at cycle 4 of an add, asynchronously between edges -> busy, done, sum and cout go to 0 immediately. No done pulse after release. A new start then completes correctly.
- Random: 1000 random a/b/cin with random start gaps, WIDTH=8 and WIDTH=16 -> every done matches {cout,sum} == a+b+cin and the done count equals the accepted start count.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one full-adder cell, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;

  // The single full-adder cell works on the current LSBs and the stored carry.
  assign w_s        = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_c        = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
  assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave IDLE on an accepted start, return after the last bit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state: busy covers exactly the RUN cycles.
  always_comb begin
    busy = 1'b0;
    if (r_state == S_RUN) busy = 1'b1;
  end

  // Operand/sum shift registers, carry and bit counter; start is ignored while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_sum_sr <= '0;
      r_carry  <= cin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_sum_sr <= w_sum_next;
      r_carry  <= w_c;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result registers are only written at completion so they hold through the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= w_last;
      if (w_last) begin
        sum  <= w_sum_next;
        cout <= w_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=16)
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int dn8 = 0, acc8 = 0, dn16 = 0, acc16 = 0;
  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Scoreboard monitors: every done pops one expected {cout,sum}.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      dn8++;
      if (q8.size() == 0) chk("done8_spurious", 64'(q8.size() > 0), 64'd1);
      else chk("result8", 64'({cout8, sum8}), 64'(q8.pop_front()));
    end
    if (rst_n && done16) begin
      dn16++;
      if (q16.size() == 0) chk("done16_spurious", 64'(q16.size() > 0), 64'd1);
      else chk("result16", 64'({cout16, sum16}), 64'(q16.pop_front()));
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] exp);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(exp);
    acc8++;
  endtask

  // Called at the negedge after the start negedge state (lat0); waits for done.
  task automatic await8(input int lat0, output int lat, output int busyc, output bit held);
    logic [8:0] r0;
    r0 = {cout8, sum8};
    lat = lat0; busyc = 0; held = 1'b1;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      lat++;
      if (!done8) begin
        busyc += int'(busy8);
        if ({cout8, sum8} !== r0) held = 1'b0;
      end
    end while (!done8 && lat < 40);
    if (!done8) chk("await8_timeout", 64'(lat), 64'd8);
  endtask

  task automatic rand8();
    for (int i = 0; i < 1000; i++) begin
      int gap;
      int lat;
      logic [7:0] ra, rb;
      logic rc;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
      issue8(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
      lat = -1;
      do begin
        @(negedge clk);
        start8 = 1'b0;
        lat++;
        if (!done8 && lat < 8 && $urandom_range(0, 7) == 0) begin
          start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
        end
      end while (!done8 && lat < 40);
      chk("rand8_latency", 64'(lat), 64'd8);
    end
  endtask

  task automatic rand16();
    for (int i = 0; i < 1000; i++) begin
      int gap;
      int lat;
      logic [15:0] ra, rb;
      logic rc;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      a16 = ra; b16 = rb; cin16 = rc; start16 = 1'b1;
      q16.push_back(17'(ra) + 17'(rb) + 17'(rc));
      acc16++;
      lat = -1;
      do begin
        @(negedge clk);
        start16 = 1'b0;
        lat++;
        if (!done16 && lat < 16 && $urandom_range(0, 7) == 0) begin
          start16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
        end
      end while (!done16 && lat < 60);
      chk("rand16_latency", 64'(lat), 64'd16);
    end
  endtask

  initial begin
    vec_t tbl[6];
    int lat, busyc, d0;
    bit held;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[4] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // Reset state
    #2;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum",  64'(sum8),  64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    chk("rst_out16", 64'({busy16, done16, cout16, sum16}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single operations
    for (int i = 0; i < 6; i++) begin
      issue8(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].sum});
      await8(-1, lat, busyc, held);
      chk("tbl_latency", 64'(lat), 64'd8);
      chk("tbl_busy_cycles", 64'(busyc), 64'd8);
      @(negedge clk);
      chk("tbl_done_width", 64'(done8), 64'd0);
    end

    // Start while busy is ignored, and operand pins changing mid-run have no effect
    d0 = dn8;
    issue8(8'h10, 8'h20, 1'b0, 9'h030);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk); start8 = 1'b0; a8 = 8'hC3; b8 = 8'h99;
    await8(3, lat, busyc, held);
    chk("ign_latency", 64'(lat), 64'd8);
    repeat (12) @(negedge clk);
    chk("ign_single_done", 64'(dn8 - d0), 64'd1);
    chk("ign_idle", 64'(busy8), 64'd0);

    // Back-to-back: second start in the done cycle; sum holds the first result meanwhile
    issue8(8'h01, 8'h02, 1'b0, 9'h003);
    await8(-1, lat, busyc, held);
    chk("b2b_first_latency", 64'(lat), 64'd8);
    issue8(8'h80, 8'h80, 1'b0, 9'h100);
    await8(-1, lat, busyc, held);
    chk("b2b_second_latency", 64'(lat), 64'd8);
    chk("b2b_sum_held", 64'(held), 64'd1);
    @(negedge clk);

    // Asynchronous reset in the middle of a run
    d0 = dn8;
    issue8(8'h5A, 8'h3C, 1'b0, 9'h096);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_sum",  64'(sum8),  64'd0);
    chk("abort_cout", 64'(cout8), 64'd0);
    acc8 -= q8.size();
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(dn8 - d0), 64'd0);
    issue8(8'h77, 8'h11, 1'b1, 9'h089);
    await8(-1, lat, busyc, held);
    chk("post_reset_latency", 64'(lat), 64'd8);
    @(negedge clk);

    // Random traffic on both widths concurrently
    fork
      rand8();
      rand16();
    join
    repeat (20) @(negedge clk);
    chk("count8", 64'(dn8), 64'(acc8));
    chk("count16", 64'(dn16), 64'(acc16));
    chk("sb8_drained", 64'(q8.size()), 64'd0);
    chk("sb16_drained", 64'(q16.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0", tot_cnt - pass_cnt);
    $fatal(1);
  end

endmodule
